// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: computes a - b - bin two bits per clock
// through a registered borrow chain, with a start/busy/done handshake.
module digit_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             last;

    logic             d0;
    logic             d1;
    logic             b0;
    logic             b1;
    logic [WIDTH+1:0] rr_cat;
    logic [WIDTH-1:0] rr_nx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath controls; DONE accepts start like IDLE.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(DIGITS - 1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Two chained full-subtractor cells over the low digit.
    always_comb begin
        d0     = ra[0] ^ rb[0] ^ br;
        b0     = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        d1     = ra[1] ^ rb[1] ^ b0;
        b1     = (~ra[1] & rb[1]) | (~(ra[1] ^ rb[1]) & b0);
        rr_cat = {d1, d0, rr};
        rr_nx  = rr_cat[WIDTH+1:2];
    end

    // Operand shift registers, borrow register, result and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            ra  <= a;
            rb  <= b;
            rr  <= '0;
            br  <= bin;
            cnt <= '0;
        end else if (step) begin
            ra  <= ra >> 2;
            rb  <= rb >> 2;
            rr  <= rr_nx;
            br  <= b1;
            cnt <= cnt + CW'(1);
        end
    end

    // Result outputs update only on the final digit; the last cycle's
    // cells see the MSB, so b0 is the borrow into it and b1 the one out.
    always_ff @(posedge clk) begin
        if (rst) begin
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (last) begin
            d    <= rr_nx;
            bout <= b1;
            ovf  <= b0 ^ b1;
            zero <= (rr_nx == '0);
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
